// File: rtl/dmem_arbiter.sv
// Round-robin arbiter that lets the CPU LSU and the debug/loader port share one
// single-port data memory, with a fixed-latency read-return tracker and contention stats.
module dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1,
  parameter int CNT_W  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset,

  input  logic                  i_m0_req,
  input  logic                  i_m0_we,
  input  logic [ADDR_W-1:0]     i_m0_addr,
  input  logic [DATA_W-1:0]     i_m0_wdata,
  input  logic [DATA_W/8-1:0]   i_m0_bmask,
  output logic                  o_m0_gnt,
  output logic                  o_m0_rvalid,
  output logic [DATA_W-1:0]     o_m0_rdata,

  input  logic                  i_m1_req,
  input  logic                  i_m1_we,
  input  logic [ADDR_W-1:0]     i_m1_addr,
  input  logic [DATA_W-1:0]     i_m1_wdata,
  input  logic [DATA_W/8-1:0]   i_m1_bmask,
  output logic                  o_m1_gnt,
  output logic                  o_m1_rvalid,
  output logic [DATA_W-1:0]     o_m1_rdata,

  output logic                  o_mem_en,
  output logic                  o_mem_we,
  output logic [ADDR_W-1:0]     o_mem_addr,
  output logic [DATA_W-1:0]     o_mem_wdata,
  output logic [DATA_W/8-1:0]   o_mem_bmask,
  input  logic [DATA_W-1:0]     i_mem_rdata,

  output logic                  o_cpu_stall,
  output logic [CNT_W-1:0]      o_conflict_cnt
);

  localparam int BM_W = DATA_W / 8;

  // lastGnt_q: 0 = master 0 granted last, 1 = master 1 granted last
  logic              lastGnt_q, lastGnt_d;
  logic [RD_LAT-1:0] pipeValid_q, pipeValid_d;
  logic [RD_LAT-1:0] pipeId_q, pipeId_d;
  logic [CNT_W-1:0]  conflictCnt_q, conflictCnt_d;

  logic m0Gnt;
  logic m1Gnt;
  logic memRead;
  logic exitValid;
  logic exitId;

  // Grants are suppressed while reset is asserted so nothing reaches memory.
  always_comb begin
    m0Gnt = 1'b0;
    m1Gnt = 1'b0;
    if (i_reset) begin
      if (i_m0_req && i_m1_req) begin
        if (lastGnt_q) begin
          m0Gnt = 1'b1;
        end else begin
          m1Gnt = 1'b1;
        end
      end else begin
        m0Gnt = i_m0_req;
        m1Gnt = i_m1_req;
      end
    end
  end

  always_comb begin
    o_mem_en    = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_mem_bmask = '0;
    if (m0Gnt) begin
      o_mem_en    = 1'b1;
      o_mem_we    = i_m0_we;
      o_mem_addr  = i_m0_addr;
      o_mem_wdata = i_m0_wdata;
      o_mem_bmask = i_m0_bmask;
    end else if (m1Gnt) begin
      o_mem_en    = 1'b1;
      o_mem_we    = i_m1_we;
      o_mem_addr  = i_m1_addr;
      o_mem_wdata = i_m1_wdata;
      o_mem_bmask = i_m1_bmask;
    end
  end

  assign memRead = (m0Gnt & ~i_m0_we) | (m1Gnt & ~i_m1_we);

  always_comb begin
    lastGnt_d = lastGnt_q;
    if (m0Gnt) begin
      lastGnt_d = 1'b0;
    end else if (m1Gnt) begin
      lastGnt_d = 1'b1;
    end

    // Stage 0 captures the read issued this cycle; the top stage lines up with i_mem_rdata.
    pipeValid_d    = '0;
    pipeId_d       = '0;
    pipeValid_d[0] = memRead;
    pipeId_d[0]    = m1Gnt;
    for (int i = 1; i < RD_LAT; i++) begin
      pipeValid_d[i] = pipeValid_q[i-1];
      pipeId_d[i]    = pipeId_q[i-1];
    end

    conflictCnt_d = conflictCnt_q;
    if (i_m0_req && i_m1_req && !(&conflictCnt_q)) begin
      conflictCnt_d = conflictCnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      lastGnt_q     <= 1'b1;
      pipeValid_q   <= '0;
      pipeId_q      <= '0;
      conflictCnt_q <= '0;
    end else begin
      lastGnt_q     <= lastGnt_d;
      pipeValid_q   <= pipeValid_d;
      pipeId_q      <= pipeId_d;
      conflictCnt_q <= conflictCnt_d;
    end
  end

  assign exitValid = pipeValid_q[RD_LAT-1];
  assign exitId    = pipeId_q[RD_LAT-1];

  assign o_m0_gnt       = m0Gnt;
  assign o_m1_gnt       = m1Gnt;
  assign o_m0_rvalid    = exitValid & ~exitId;
  assign o_m1_rvalid    = exitValid & exitId;
  assign o_m0_rdata     = o_m0_rvalid ? i_mem_rdata : '0;
  assign o_m1_rdata     = o_m1_rvalid ? i_mem_rdata : '0;
  assign o_cpu_stall    = i_m0_req & ~m0Gnt;
  assign o_conflict_cnt = conflictCnt_q;

  logic unusedBm;
  assign unusedBm = (BM_W == 0);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: one instance at default parameters and one with
// RD_LAT=3, CNT_W=4, both driven by the same stimulus.
module tb_dmem_arbiter;

  logic        clock = 1'b0;
  logic        resetN = 1'b0;

  logic        m0Req, m0We, m1Req, m1We;
  logic [31:0] m0Addr, m0Wdata, m1Addr, m1Wdata, memRdata;
  logic [3:0]  m0Bmask, m1Bmask;

  logic        m0Gnt, m0Rvalid, m1Gnt, m1Rvalid, memEn, memWe, cpuStall;
  logic [31:0] m0Rdata, m1Rdata, memAddr, memWdata;
  logic [3:0]  memBmask;
  logic [15:0] conflictCnt;

  logic        bM0Gnt, bM0Rvalid, bM1Gnt, bM1Rvalid, bMemEn, bMemWe, bCpuStall;
  logic [31:0] bM0Rdata, bM1Rdata, bMemAddr, bMemWdata;
  logic [3:0]  bMemBmask;
  logic [3:0]  bConflictCnt;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  dmem_arbiter dut (
    .i_clk(clock), .i_reset(resetN),
    .i_m0_req(m0Req), .i_m0_we(m0We), .i_m0_addr(m0Addr), .i_m0_wdata(m0Wdata), .i_m0_bmask(m0Bmask),
    .o_m0_gnt(m0Gnt), .o_m0_rvalid(m0Rvalid), .o_m0_rdata(m0Rdata),
    .i_m1_req(m1Req), .i_m1_we(m1We), .i_m1_addr(m1Addr), .i_m1_wdata(m1Wdata), .i_m1_bmask(m1Bmask),
    .o_m1_gnt(m1Gnt), .o_m1_rvalid(m1Rvalid), .o_m1_rdata(m1Rdata),
    .o_mem_en(memEn), .o_mem_we(memWe), .o_mem_addr(memAddr), .o_mem_wdata(memWdata),
    .o_mem_bmask(memBmask), .i_mem_rdata(memRdata),
    .o_cpu_stall(cpuStall), .o_conflict_cnt(conflictCnt)
  );

  dmem_arbiter #(.RD_LAT(3), .CNT_W(4)) dutB (
    .i_clk(clock), .i_reset(resetN),
    .i_m0_req(m0Req), .i_m0_we(m0We), .i_m0_addr(m0Addr), .i_m0_wdata(m0Wdata), .i_m0_bmask(m0Bmask),
    .o_m0_gnt(bM0Gnt), .o_m0_rvalid(bM0Rvalid), .o_m0_rdata(bM0Rdata),
    .i_m1_req(m1Req), .i_m1_we(m1We), .i_m1_addr(m1Addr), .i_m1_wdata(m1Wdata), .i_m1_bmask(m1Bmask),
    .o_m1_gnt(bM1Gnt), .o_m1_rvalid(bM1Rvalid), .o_m1_rdata(bM1Rdata),
    .o_mem_en(bMemEn), .o_mem_we(bMemWe), .o_mem_addr(bMemAddr), .o_mem_wdata(bMemWdata),
    .o_mem_bmask(bMemBmask), .i_mem_rdata(memRdata),
    .o_cpu_stall(bCpuStall), .o_conflict_cnt(bConflictCnt)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                               input logic [3:0] b0, input logic r1, input logic w1, input logic [31:0] a1,
                               input logic [31:0] d1, input logic [3:0] b1, input logic [31:0] rd);
    m0Req = r0; m0We = w0; m0Addr = a0; m0Wdata = d0; m0Bmask = b0;
    m1Req = r1; m1We = w1; m1Addr = a1; m1Wdata = d1; m1Bmask = b1;
    memRdata = rd;
  endtask

  task automatic idle(input logic [31:0] rd);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, rd);
  endtask

  task automatic nextCycle();
    @(posedge clock);
    #1;
  endtask

  task automatic resetDut();
    resetN = 1'b0;
    idle(32'h0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    checkOutput("rst_m0Gnt", m0Gnt, 0);
    checkOutput("rst_m1Gnt", m1Gnt, 0);
    checkOutput("rst_memEn", memEn, 0);
    checkOutput("rst_memAddr", memAddr, 0);
    checkOutput("rst_m0Rvalid", m0Rvalid, 0);
    checkOutput("rst_cnt", conflictCnt, 0);
    checkOutput("rst_bCnt", bConflictCnt, 0);
    resetN = 1'b1;
    nextCycle();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic eM0, eM1, eV0, eV1;

    idle(32'h0);
    resetDut();

    // Single m0 read, RD_LAT=1
    applyStimulus(1, 0, 32'h10, 32'h0, 4'hF, 0, 0, 32'h0, 32'h0, 4'h0, 32'h0);
    @(negedge clock);
    checkOutput("t1_m0Gnt", m0Gnt, 1);
    checkOutput("t1_m1Gnt", m1Gnt, 0);
    checkOutput("t1_memEn", memEn, 1);
    checkOutput("t1_memWe", memWe, 0);
    checkOutput("t1_memAddr", memAddr, 32'h10);
    checkOutput("t1_memBmask", memBmask, 4'hF);
    checkOutput("t1_stall", cpuStall, 0);
    checkOutput("t1_m0RvalidEarly", m0Rvalid, 0);
    nextCycle();
    idle(32'hDEAD_BEEF);
    @(negedge clock);
    checkOutput("t1_m0Rvalid", m0Rvalid, 1);
    checkOutput("t1_m0Rdata", m0Rdata, 32'hDEAD_BEEF);
    checkOutput("t1_m1Rvalid", m1Rvalid, 0);
    checkOutput("t1_m1Rdata", m1Rdata, 0);
    checkOutput("t1_idleMemEn", memEn, 0);
    checkOutput("t1_idleMemAddr", memAddr, 0);
    checkOutput("t1_idleMemBmask", memBmask, 0);
    nextCycle();
    @(negedge clock);
    checkOutput("t1_m0RvalidOnce", m0Rvalid, 0);
    checkOutput("t1_m0RdataAfter", m0Rdata, 0);

    // Continuous contention: grants alternate m0,m1,m0,m1 and returns follow one cycle later
    resetDut();
    for (int k = 0; k <= 4; k++) begin
      if (k < 4)
        applyStimulus(1, 0, 32'h20 + k, 32'h0, 4'hF, 1, 0, 32'h40 + k, 32'h0, 4'hF, 32'hA000_0000 + k);
      else
        idle(32'hA000_0000 + k);
      eM0 = (k < 4) && (k % 2 == 0);
      eM1 = (k < 4) && (k % 2 == 1);
      eV0 = (k >= 1) && ((k - 1) % 2 == 0);
      eV1 = (k >= 1) && ((k - 1) % 2 == 1);
      @(negedge clock);
      checkOutput("t2_m0Gnt", m0Gnt, eM0);
      checkOutput("t2_m1Gnt", m1Gnt, eM1);
      checkOutput("t2_stall", cpuStall, eM1);
      checkOutput("t2_memAddr", memAddr, eM0 ? 32'h20 + k : (eM1 ? 32'h40 + k : 32'h0));
      checkOutput("t2_m0Rvalid", m0Rvalid, eV0);
      checkOutput("t2_m1Rvalid", m1Rvalid, eV1);
      checkOutput("t2_m0Rdata", m0Rdata, eV0 ? 32'hA000_0000 + k : 32'h0);
      checkOutput("t2_m1Rdata", m1Rdata, eV1 ? 32'hA000_0000 + k : 32'h0);
      checkOutput("t2_cnt", conflictCnt, k);
      nextCycle();
    end

    // m1 write alone
    applyStimulus(0, 0, 32'h0, 32'h0, 4'h0, 1, 1, 32'h100, 32'h1234_5678, 4'b0011, 32'h0);
    @(negedge clock);
    checkOutput("t3_m1Gnt", m1Gnt, 1);
    checkOutput("t3_m0Gnt", m0Gnt, 0);
    checkOutput("t3_memEn", memEn, 1);
    checkOutput("t3_memWe", memWe, 1);
    checkOutput("t3_memAddr", memAddr, 32'h100);
    checkOutput("t3_memWdata", memWdata, 32'h1234_5678);
    checkOutput("t3_memBmask", memBmask, 4'b0011);
    checkOutput("t3_m1RvalidNow", m1Rvalid, 0);
    nextCycle();
    idle(32'h5555_5555);
    @(negedge clock);
    checkOutput("t3_m0Rvalid", m0Rvalid, 0);
    checkOutput("t3_m1Rvalid", m1Rvalid, 0);
    checkOutput("t3_m1Rdata", m1Rdata, 0);
    repeat (3) nextCycle();

    // RD_LAT=3: m0 reads at 0,1,2 return at 3,4,5; an m1 write at 3 must not disturb them
    for (int k = 0; k <= 6; k++) begin
      if (k < 3)
        applyStimulus(1, 0, 32'h200 + 4 * k, 32'h0, 4'hF, 0, 0, 32'h0, 32'h0, 4'h0, 32'hC000_0000 + k);
      else if (k == 3)
        applyStimulus(0, 0, 32'h0, 32'h0, 4'h0, 1, 1, 32'h300, 32'h0000_CAFE, 4'hF, 32'hC000_0000 + k);
      else
        idle(32'hC000_0000 + k);
      eV0 = (k >= 3) && (k <= 5);
      @(negedge clock);
      checkOutput("t4_bM0Gnt", bM0Gnt, k < 3);
      checkOutput("t4_bM1Gnt", bM1Gnt, k == 3);
      checkOutput("t4_bM0Rvalid", bM0Rvalid, eV0);
      checkOutput("t4_bM0Rdata", bM0Rdata, eV0 ? 32'hC000_0000 + k : 32'h0);
      checkOutput("t4_bM1Rvalid", bM1Rvalid, 0);
      nextCycle();
    end

    // Reset while an RD_LAT=3 read is in flight
    applyStimulus(1, 0, 32'h400, 32'h0, 4'hF, 1, 1, 32'h500, 32'h0000_BEEF, 4'hF, 32'hFFFF_FFFF);
    @(negedge clock);
    checkOutput("t5_bM0GntTie", bM0Gnt, 1);
    checkOutput("t5_bM1GntTie", bM1Gnt, 0);
    nextCycle();
    resetN = 1'b0;
    applyStimulus(1, 1, 32'h600, 32'h66, 4'hF, 1, 1, 32'h500, 32'h0000_BEEF, 4'hF, 32'hFFFF_FFFF);
    for (int j = 0; j < 4; j++) begin
      @(negedge clock);
      checkOutput("t5_rstBM0Gnt", bM0Gnt, 0);
      checkOutput("t5_rstBM1Gnt", bM1Gnt, 0);
      checkOutput("t5_rstBMemEn", bMemEn, 0);
      checkOutput("t5_rstBM0Rvalid", bM0Rvalid, 0);
      checkOutput("t5_rstBCnt", bConflictCnt, 0);
      nextCycle();
    end
    @(negedge clock);
    resetN = 1'b1;
    #1;
    checkOutput("t5_relBM0Gnt", bM0Gnt, 1);
    checkOutput("t5_relBM1Gnt", bM1Gnt, 0);
    checkOutput("t5_relM0Gnt", m0Gnt, 1);
    checkOutput("t5_relBMemAddr", bMemAddr, 32'h600);
    checkOutput("t5_relBCnt", bConflictCnt, 0);
    nextCycle();
    applyStimulus(0, 0, 32'h0, 32'h0, 4'h0, 1, 1, 32'h500, 32'h0000_BEEF, 4'hF, 32'hFFFF_FFFF);
    @(negedge clock);
    checkOutput("t5_postBM1Gnt", bM1Gnt, 1);
    checkOutput("t5_postBCnt", bConflictCnt, 1);
    checkOutput("t5_postCnt", conflictCnt, 1);
    checkOutput("t5_postBM0Rvalid", bM0Rvalid, 0);
    for (int j = 0; j < 3; j++) begin
      nextCycle();
      idle(32'hFFFF_FFFF);
      @(negedge clock);
      checkOutput("t5_postBM0Rvalid", bM0Rvalid, 0);
      checkOutput("t5_postBM1Rvalid", bM1Rvalid, 0);
      checkOutput("t5_postM0Rvalid", m0Rvalid, 0);
    end
    nextCycle();

    // Counter saturation with CNT_W=4 versus an unsaturated 16-bit counter
    resetDut();
    applyStimulus(1, 1, 32'h700, 32'h7, 4'hF, 1, 1, 32'h704, 32'h8, 4'hF, 32'h0);
    for (int k = 0; k <= 20; k++) begin
      if (k == 20) idle(32'h0);
      @(negedge clock);
      checkOutput("t6_bCnt", bConflictCnt, (k > 15) ? 15 : k);
      checkOutput("t6_cnt", conflictCnt, k);
      nextCycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-master arbiter sharing the single-port data memory behind the LSU between the CPU load/store path (master 0) and a debug/program-loader port (master 1). It issues at most one access per cycle using round-robin on contention and tracks read returns through a fixed-latency pipeline. It also provides a CPU stall flag and a saturating contention counter. The block sits between the core's LSU request path and the dmem/IO address decoder.

Parameters:
ADDR_W, 32, address width of masters and memory
DATA_W, 32, data width; byte-mask width is DATA_W/8
RD_LAT, 1, memory read latency in cycles, from accepted read to i_mem_rdata valid; legal range 1..4
CNT_W, 16, width of contention counter

Ports:
i_clk  in  1  clock, rising edge
i_reset  in  1  asynchronous, active-low reset
i_m0_req  in  1  master 0 (CPU) request
i_m0_we  in  1  master 0 write enable (0 = read)
i_m0_addr  in  ADDR_W  master 0 address
i_m0_wdata  in  DATA_W  master 0 write data
i_m0_bmask  in  DATA_W/8  master 0 byte mask
o_m0_gnt  out  1  master 0 request accepted this cycle
o_m0_rvalid  out  1  master 0 read data valid
o_m0_rdata  out  DATA_W  master 0 read data
i_m1_req, i_m1_we, i_m1_addr, i_m1_wdata, i_m1_bmask  in  as master 0  master 1 (debug/loader) request
o_m1_gnt, o_m1_rvalid, o_m1_rdata  out  as master 0  master 1 responses
o_mem_en  out  1  memory access strobe
o_mem_we  out  1  memory write enable
o_mem_addr  out  ADDR_W  memory address
o_mem_wdata  out  DATA_W  memory write data
o_mem_bmask  out  DATA_W/8  memory byte mask
i_mem_rdata  in  DATA_W  memory read data, valid RD_LAT cycles after read strobe
o_cpu_stall  out  1  i_m0_req & ~o_m0_gnt
o_conflict_cnt  out  CNT_W  cycles with both requests asserted, saturating

Behaviour:
- Reset (i_reset=0, asynchronous): every gnt/rvalid/mem_en/mem_we = 0; rdata, mem_addr, mem_wdata, mem_bmask = 0; o_conflict_cnt = 0; last-grant pointer = 1, so master 0 wins the first tie; read-tracking pipeline cleared.
- Grant logic is combinational in the issue cycle. A master holds req, we, addr, wdata and bmask stable until it sees gnt. Grant means the access was presented to memory in that cycle.
- Exactly one master request: that master is granted.
- Both masters request: grant the master not pointed to by the last-grant pointer. The pointer updates on the clock edge to the granted master. With no grant, the pointer holds.
- No request: o_mem_en=0 and memory outputs = 0.
- o_mem_* mirror the granted master's fields in the same cycle; o_mem_en = o_m0_gnt | o_m1_gnt.
- Write: single cycle, no response beyond gnt.
- Read: push {valid, master id} into an RD_LAT-deep shift pipeline. When an entry exits the pipeline, assert o_mX_rvalid for that master for exactly 1 cycle and drive o_mX_rdata = i_mem_rdata. The other master's rvalid stays 0 and its rdata = 0.
- Back-to-back reads, alternating or same master, are fully pipelined: one read return per cycle with no bubble. Return order equals grant order.
- A write granted while reads are in flight does not disturb returns.
- o_conflict_cnt increments on each cycle with i_m0_req & i_m1_req and saturates at 2^CNT_W-1; it never wraps.
- Reset asserted mid-operation: in-flight reads are discarded and no rvalid appears after reset release. Requests held across reset release are arbitrated fresh, with master 0 winning a tie.
- A request arriving in the same cycle as a grant to the other master waits one cycle; worst-case wait under continuous contention is 1 cycle.

Test Plan:
- Reset then m0 read addr 0x0000_0010, mem returns 0xDEAD_BEEF, RD_LAT=1 -> o_m0_gnt=1 cycle 0, o_m0_rvalid=1 with rdata 0xDEAD_BEEF in cycle 1 only; o_m1_rvalid=0.
- Both masters request reads continuously for 4 cycles after reset -> grants m0,m1,m0,m1; rvalid alternates with the same order one cycle later; o_conflict_cnt=4; o_cpu_stall=1 in cycles 1 and 3.
- m1 write addr 0x100, wdata 0x1234_5678, bmask 4'b0011, alone -> o_mem_en=1, o_mem_we=1, mem fields match in the same cycle; no rvalid on either master.
- RD_LAT=3, m0 reads at cycles 0,1,2 -> o_m0_rvalid high in cycles 3,4,5 carrying the respective i_mem_rdata values.
- Read granted, then i_reset=0 before return -> rvalid stays 0 through reset and after release; pointer and counter reset; next tie goes to m0.
- CNT_W=4, both requests held 20 cycles -> o_conflict_cnt saturates at 15 and holds.
